// File: rtl/sha3_pkg.sv
// sha3_pkg: shared SHA3 mode encoding, state width and digest length helpers
package sha3_pkg;
  typedef enum logic [1:0] {SHA3_224, SHA3_256, SHA3_384, SHA3_512} sha3_mode_e;
  localparam int SHA3_STATE_W = 1600;
  function automatic int sha3_digest_bytes(sha3_mode_e mode);
    return mode == SHA3_224 ? 28 : mode == SHA3_256 ? 32 : mode == SHA3_384 ? 48 : 64;
  endfunction
  function automatic int sha3_num_beats(sha3_mode_e mode, int out_w);
    return (sha3_digest_bytes(mode) * 8 + out_w - 1) / out_w;
  endfunction
endpackage

// File: rtl/sha3_digest_serializer.sv
// sha3_digest_serializer: captures a Keccak state and streams the mode's digest in OUT_W-bit beats (SHA3_DIGEST_LE_BEAT_EN reverses byte order within a beat)
module sha3_digest_serializer
  import sha3_pkg::*;
#(
  parameter int STATE_W = SHA3_STATE_W,
  parameter int OUT_W = 64,
  parameter int MAX_DIGEST_BITS = 512
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] state_i,
  input  logic               state_valid,
  output logic               state_ready,
  input  logic [1:0]         mode_i,
  output logic [OUT_W-1:0]   dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               dout_last,
  output logic [OUT_W/8-1:0] dout_keep,
  output logic               busy,
  output logic               finish_hash
);
  localparam int W = OUT_W / 8;
  localparam int MB = MAX_DIGEST_BITS / 8;
  localparam int CW = $clog2(MB) + 1;
  localparam int IW = $clog2(MAX_DIGEST_BITS);
  typedef enum logic [1:0] {IDLE, SEND, DONE} st_e;
  st_e st, st_n;
  logic [MAX_DIGEST_BITS-1:0] digest, cap;
  logic [CW-1:0] db, nb, cnt, db_cap, nb_cap;
  logic [IW-1:0] off;
  logic [OUT_W-1:0] win, beat;
  logic [W-1:0] kv;
  logic last_beat, unused;
  assign unused = ^state_i[STATE_W-1:MAX_DIGEST_BITS];
  assign db_cap = CW'(sha3_digest_bytes(sha3_mode_e'(mode_i)));
  assign nb_cap = CW'(sha3_num_beats(sha3_mode_e'(mode_i), OUT_W));
  assign last_beat = cnt == nb - 1'b1;
  assign off = IW'(cnt) * IW'(OUT_W);
  assign win = digest[off +: OUT_W];
  for (genvar j = 0; j < MB; j++) begin : g_cap
    assign cap[8*j +: 8] = CW'(j) < db_cap ? state_i[8*j +: 8] : 8'h00;
  end
  for (genvar i = 0; i < W; i++) begin : g_beat
    logic kb;
    assign kb = 8'(cnt) * 8'(W) + 8'(i) < 8'(db);
`ifdef SHA3_DIGEST_LE_BEAT_EN
    assign beat[8*i +: 8] = win[8*i +: 8];
    assign kv[i] = kb;
`else
    assign beat[OUT_W-1-8*i -: 8] = win[8*i +: 8];
    assign kv[W-1-i] = kb;
`endif
  end
  // state register
  always_ff @(posedge clk)
    st <= reset ? IDLE : st_n;
  // next state: capture in IDLE, leave SEND on the final accepted beat, DONE lasts one cycle
  always_comb
    st_n = st == IDLE ? (state_valid ? SEND : IDLE) :
           st == SEND ? (dout_ready && last_beat ? DONE : SEND) : IDLE;
  // digest capture and beat counter
  always_ff @(posedge clk) begin
    if (reset) begin
      digest <= '0;
      db <= '0;
      nb <= '0;
      cnt <= '0;
    end else if (st == IDLE && state_valid) begin
      digest <= cap;
      db <= db_cap;
      nb <= nb_cap;
      cnt <= '0;
    end else if (st == SEND && dout_ready) begin
      cnt <= cnt + 1'b1;
    end
  end
  // outputs decoded from state; beat data is gated to zero outside SEND
  always_comb begin
    state_ready = st == IDLE;
    dout_valid = st == SEND;
    busy = st != IDLE;
    finish_hash = st == DONE;
    dout = dout_valid ? beat : '0;
    dout_keep = dout_valid ? kv : '0;
    dout_last = dout_valid && last_beat;
  end
endmodule

// File: tb/tb_sha3_digest_serializer.sv
// tb_sha3_digest_serializer: randomized self-checking bench for 64- and 32-bit beat builds
module tb_sha3_digest_serializer;
  typedef struct packed {logic [63:0] d; logic [7:0] k; logic l;} beat_t;
  logic clk = 0, reset = 1;
  logic [1599:0] state = '0;
  logic [1:0] mode = 0, sv = 0, rdy = 2'b11;
  logic [63:0] d_a [2];
  logic [7:0] k_a [2];
  logic [1:0] dv_a, dl_a, sr_a, busy_a, fin_a, stall = 0;
  beat_t q [2][$];
  beat_t pb [2];
  logic [7:0] sb_nxt [64];
  logic [7:0] sb_exp [64];
  int acc_t [2];
  int cyc = 0, checks = 0, errors = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int OW = g == 0 ? 64 : 32;
    logic [OW-1:0] dout;
    logic [OW/8-1:0] keep;
    sha3_digest_serializer #(.OUT_W(OW)) u_dut (
      .clk(clk), .reset(reset), .state_i(state), .state_valid(sv[g]), .state_ready(sr_a[g]),
      .mode_i(mode), .dout(dout), .dout_valid(dv_a[g]), .dout_ready(rdy[g]), .dout_last(dl_a[g]),
      .dout_keep(keep), .busy(busy_a[g]), .finish_hash(fin_a[g]));
    assign d_a[g] = 64'(dout);
    assign k_a[g] = 8'(keep);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic beat_t model(int w, int m, int k);
    beat_t r = '0;
    int db = m == 0 ? 28 : m == 1 ? 32 : m == 2 ? 48 : 64;
    int wb = w / 8;
    int nb = (db * 8 + w - 1) / w;
    for (int i = 0; i < wb; i++) begin
      int b;
      logic [7:0] by;
      b = k * wb + i;
      by = b < db ? sb_exp[b] : 8'h00;
`ifdef SHA3_DIGEST_LE_BEAT_EN
      r.d = r.d | (64'(by) << (8 * i));
      r.k = r.k | (8'(b < db) << i);
`else
      r.d = (r.d << 8) | 64'(by);
      r.k = (r.k << 1) | 8'(b < db);
`endif
    end
    r.l = k == nb - 1;
    return r;
  endfunction
  always @(negedge clk)
    for (int g = 0; g < 2; g++) begin
      if (reset) stall[g] <= 1'b0;
      else begin
        if (stall[g]) begin
          check("hold_valid", 64'(dv_a[g]), 1);
          check("hold_data", d_a[g], pb[g].d);
          check("hold_keep", 64'(k_a[g]), 64'(pb[g].k));
          check("hold_last", 64'(dl_a[g]), 64'(pb[g].l));
        end
        if (dv_a[g] && rdy[g]) begin
          q[g].push_back('{d: d_a[g], k: k_a[g], l: dl_a[g]});
          if (dl_a[g]) acc_t[g] = cyc;
        end
        stall[g] <= dv_a[g] && !rdy[g];
        pb[g] <= '{d: d_a[g], k: k_a[g], l: dl_a[g]};
      end
    end
  task automatic set_state(input bit seq);
    for (int j = 0; j < 200; j++) begin
      logic [7:0] by;
      by = seq ? 8'(j) : 8'($urandom);
      state[8*j +: 8] = by;
      if (j < 64) sb_nxt[j] = by;
    end
  endtask
  task automatic kick(input int s, input int m);
    @(posedge clk); #1;
    q[s].delete();
    sb_exp = sb_nxt;
    mode = 2'(m);
    sv[s] = 1'b1;
    @(posedge clk); #1;
    sv[s] = 1'b0;
  endtask
  task automatic drain(input int s, input int m, input bit rnd);
    int w = s == 0 ? 64 : 32;
    int db = m == 0 ? 28 : m == 1 ? 32 : m == 2 ? 48 : 64;
    int nb = (db * 8 + w - 1) / w;
    bit done = 0;
    beat_t e;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (fin_a[s]) done = 1;
      else begin
        @(posedge clk); #1;
        rdy[s] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    rdy[s] = 1'b1;
    check("finish_seen", 64'(done), 1);
    check("beat_count", 64'(q[s].size()), 64'(nb));
    for (int k = 0; k < nb && k < q[s].size(); k++) begin
      e = model(w, m, k);
      check("beat_data", q[s][k].d, e.d);
      check("beat_keep", 64'(q[s][k].k), 64'(e.k));
      check("beat_last", 64'(q[s][k].l), 64'(e.l));
    end
    check("finish_latency", 64'(cyc - acc_t[s]), 1);
    @(negedge clk);
    check("finish_pulse", 64'(fin_a[s]), 0);
  endtask
  task automatic check_idle(input string tag, input int s);
    check({tag, "_ready"}, 64'(sr_a[s]), 1);
    check({tag, "_valid"}, 64'(dv_a[s]), 0);
    check({tag, "_dout"}, d_a[s], 0);
    check({tag, "_keep"}, 64'(k_a[s]), 0);
    check({tag, "_last"}, 64'(dl_a[s]), 0);
    check({tag, "_busy"}, 64'(busy_a[s]), 0);
    check({tag, "_fin"}, 64'(fin_a[s]), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check_idle("reset0", 0);
    check_idle("reset1", 1);
    set_state(1);
    kick(0, 1);
    drain(0, 1, 0);
    check("t1_first", q[0][0].d, 64'h0001020304050607);
    check("t1_fourth", q[0][3].d, 64'h18191A1B1C1D1E1F);
    kick(0, 0);
    drain(0, 0, 0);
`ifdef SHA3_DIGEST_LE_BEAT_EN
    check("t2_last", q[0][3].d, 64'h000000001B1A1918);
    check("t2_keep", 64'(q[0][3].k), 64'h0F);
`else
    check("t2_last", q[0][3].d, 64'h18191A1B00000000);
    check("t2_keep", 64'(q[0][3].k), 64'hF0);
`endif
    kick(1, 3);
    drain(1, 3, 1);
`ifdef SHA3_DIGEST_LE_BEAT_EN
    check("t3_first", q[1][0].d, 64'h03020100);
    check("t3_last", q[1][15].d, 64'h3F3E3D3C);
`else
    check("t3_first", q[1][0].d, 64'h00010203);
    check("t3_last", q[1][15].d, 64'h3C3D3E3F);
`endif
    kick(0, 2);
    set_state(0);
    mode = 2'd0;
    sv[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t4_ready_low", 64'(sr_a[0]), 0);
      check("t4_busy", 64'(busy_a[0]), 1);
    end
    drain(0, 2, 1);
    check("t6_idle_ready", 64'(sr_a[0]), 1);
    check("t6_idle_valid", 64'(dv_a[0]), 0);
    q[0].delete();
    sb_exp = sb_nxt;
    @(posedge clk); #1;
    sv[0] = 1'b0;
    @(negedge clk);
    check("t6_second_valid", 64'(dv_a[0]), 1);
    drain(0, 0, 0);
    set_state(0);
    kick(0, 3);
    for (int c = 0; c < 50 && q[0].size() < 2; c++) @(negedge clk);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check_idle("t5_reset", 0);
    repeat (4) begin
      @(negedge clk);
      check("t5_no_finish", 64'(fin_a[0]), 0);
    end
    set_state(0);
    kick(0, 1);
    drain(0, 1, 1);
    for (int n = 0; n < 8; n++) begin
      int s, m;
      s = $urandom_range(0, 1);
      m = $urandom_range(0, 3);
      set_state(0);
      kick(s, m);
      drain(s, m, 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
